clkgen_multi: RTL and testbench
===============================

# clkgen_multi

Multi-channel programmable clock-strobe generator. It is the parametrised successor to the single-channel divider and feeds the tone and envelope sections of the sound generator. Each of CH channels divides clk_i by a programmable period and produces a one-cycle strobe and, optionally, a 50 % square wave. Period changes are double-buffered so they take effect only at a period boundary, which keeps the output glitch-free.

## Interface
Parameters:
- N, 16, counter/period width per channel
- CH, 4, number of independent channels

Ports:
- clk_i  in  1  clock
- reset  in  1  reset, synchronous, active-high
- en_i  in  CH  per-channel run enable
- maxval_i  in  CH*N  per-channel period value; channel c occupies bits [c*N +: N]; output period is maxval+1 cycles
- load_i  in  CH  per-channel write strobe; captures the maxval_i slice into that channel's shadow register
- sync_i  in  1  restart all channels in phase
- strobe_o  out  CH  one-cycle pulse per period
- square_o  out  CH  toggles once per period (square wave)
- pending_o  out  CH  shadow value written but not yet applied

## Operation
- Per-channel state: ctr (N bits), per (active period, N bits), shadow (N bits), pend, strobe, square.
- Reset: ctr=0, per=0, shadow=0, pend=0, strobe_o=0, square_o=0, pending_o=0.
- load_i[c]=1: shadow<=maxval_i slice and pend<=1. A second load before the boundary overwrites shadow (last write wins).
- When en_i[c]=1 and ctr>=per (wrap):
  - ctr<=0, strobe<=1, square<=~square.
  - If pend, then per<=shadow and pend<=0.
- When en_i[c]=1 and ctr<per: ctr<=ctr+1, strobe<=0.
- When en_i[c]=0: ctr, square and per hold; strobe<=0. Loads are still accepted.
- Load in the same cycle as a wrap: maxval_i is applied directly to per at that wrap, and pend ends at 0.
- sync_i=1, applied to all channels regardless of en_i:
  - ctr<=0, strobe<=0, square<=0.
  - Pending shadows are applied immediately (per<=shadow, pend<=0).
  - A load in the same cycle as sync_i is applied directly.
- Priority: reset > sync_i > wrap/count.
- per=0: strobe_o stays high continuously while enabled, and square_o toggles every cycle.
- The >= comparison guarantees a wrap on the next enabled cycle even if ctr>per.

## Timing
- All outputs are registered; no combinational path from input to output.
- With en high and per=P from reset release, ctr counts 0..P. strobe_o is high for exactly one cycle after the (P+1)-th enabled edge, then once every P+1 enabled cycles.
- square_o period is 2*(P+1) cycles, duty 50 %.
- A period change takes effect from the first period after the next wrap. The strobe spacing is never a mix of old and new values.
- pending_o rises on the cycle after load_i and falls on the cycle after the applying wrap or sync_i.
- Reset mid-period: all outputs read 0 on the next cycle, and the loaded shadow is lost.

## Configuration
- CLKGEN_MULTI_SQUARE_EN defined: square registers and square_o toggling are implemented as described above.
- Not defined: the square logic is removed and square_o is tied to 0; all other behaviour is unchanged.

## Structure
- Shared package clkgen_pkg holds:
  - default N and CH constants
  - a typedef for the period word (logic [N-1:0])
  - a helper constant for the flattened bus width
- Natural sub-module: clkgen_ch, one channel containing the counter, period, shadow and outputs, instantiated CH times by a generate loop.
- clkgen_multi itself only slices buses and fans out sync_i and reset.

## Test plan
- CH=4, N=16. Channel 0 loaded with 3, en high -> strobe_o[0] pulses every 4 cycles, square_o[0] period is 8, first pulse after the 4th enabled edge.
- Channel 1 running at per=9. Load 2 at ctr=4 -> pending_o[1]=1 until the wrap; the pulse gap stays 10, then gaps of 3 follow and pending_o[1] clears.
- Load 7 then 5 before the boundary on channel 2 -> the period becomes 6 (last write wins).
- per=0 with en high -> strobe_o stays 1 continuously and square_o toggles every cycle.
- en_i[3] dropped for 5 cycles mid-period -> ctr and square freeze, strobe_o[3]=0, and the next pulse is delayed by exactly 5 cycles.
- sync_i pulse with channels at different phases, and reset asserted mid-period -> after sync all strobes align at their per+1 spacing with square_o=0; after reset all outputs read 0 on the next cycle.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared constants and types for the multi-channel clock-strobe generator.
package clkgen_pkg;

   localparam int N_DEF  = 16;
   localparam int CH_DEF = 4;

   typedef logic [N_DEF-1:0] period_t;

   localparam int BUS_W_DEF = N_DEF * CH_DEF;

   function automatic int bus_width(input int n, input int ch);
      return n * ch;
   endfunction

endpackage

// File: rtl/clkgen_ch.sv
// One strobe/square channel: counter, active period, double-buffered shadow period.
// Square output is built only when CLKGEN_MULTI_SQUARE_EN is defined.
module clkgen_ch
   import clkgen_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk_i,
   input  logic         reset,
   input  logic         sync,
   input  logic         en,
   input  logic         load,
   input  logic [N-1:0] maxval,
   output logic         strobe,
   output logic         square,
   output logic         pending
);

   logic [N-1:0] ctr_q, ctr_nxt;
   logic [N-1:0] per_q, per_nxt;
   logic [N-1:0] shadow_q, shadow_nxt;
   logic         pend_q, pend_nxt;
   logic         strobe_q, strobe_nxt;
   logic         wrap;
   logic         apply;

   assign wrap  = en && (ctr_q >= per_q);
   assign apply = sync || wrap;

   always_comb begin
      ctr_nxt    = ctr_q;
      per_nxt    = per_q;
      shadow_nxt = shadow_q;
      pend_nxt   = pend_q;
      strobe_nxt = 1'b0;

      if (load) begin
         shadow_nxt = maxval;
         pend_nxt   = 1'b1;
      end

      // A boundary (wrap or sync) swaps in the new period; a same-cycle load wins over the shadow.
      if (apply) begin
         if (load) begin
            per_nxt  = maxval;
            pend_nxt = 1'b0;
         end else if (pend_q) begin
            per_nxt  = shadow_q;
            pend_nxt = 1'b0;
         end
      end

      if (sync) begin
         ctr_nxt = '0;
      end else if (wrap) begin
         ctr_nxt    = '0;
         strobe_nxt = 1'b1;
      end else if (en) begin
         ctr_nxt = ctr_q + N'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         ctr_q    <= '0;
         per_q    <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         ctr_q    <= ctr_nxt;
         per_q    <= per_nxt;
         shadow_q <= shadow_nxt;
         pend_q   <= pend_nxt;
         strobe_q <= strobe_nxt;
      end
   end

`ifdef CLKGEN_MULTI_SQUARE_EN
   logic square_q;

   always_ff @(posedge clk_i) begin
      if (reset || sync) begin
         square_q <= 1'b0;
      end else if (wrap) begin
         square_q <= ~square_q;
      end
   end

   assign square = square_q;
`else
   assign square = 1'b0;
`endif

   assign strobe  = strobe_q;
   assign pending = pend_q;

endmodule

// File: rtl/clkgen_multi.sv
// CH-channel programmable clock-strobe generator; slices the buses and fans out sync/reset.
// Optional square-wave outputs: define CLKGEN_MULTI_SQUARE_EN.
module clkgen_multi
   import clkgen_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int CH = CH_DEF
) (
   input  logic                      clk_i,
   input  logic                      reset,
   input  logic [CH-1:0]             en_i,
   input  logic [bus_width(N,CH)-1:0] maxval_i,
   input  logic [CH-1:0]             load_i,
   input  logic                      sync_i,
   output logic [CH-1:0]             strobe_o,
   output logic [CH-1:0]             square_o,
   output logic [CH-1:0]             pending_o
);

   for (genvar c = 0; c < CH; c++) begin : g_ch
      clkgen_ch #(
         .N (N)
      ) u_ch (
         .clk_i   (clk_i),
         .reset   (reset),
         .sync    (sync_i),
         .en      (en_i[c]),
         .load    (load_i[c]),
         .maxval  (maxval_i[c*N +: N]),
         .strobe  (strobe_o[c]),
         .square  (square_o[c]),
         .pending (pending_o[c])
      );
   end

endmodule

// File: tb/tb_clkgen_multi.sv
// Scoreboard bench for clkgen_multi: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_clkgen_multi;

   localparam int N  = 16;
   localparam int CH = 4;

   logic             clk_i = 1'b0;
   logic             reset;
   logic [CH-1:0]    en_i;
   logic [CH-1:0]    load_i;
   logic             sync_i;
   logic [N-1:0]     mv [CH];
   logic [N*CH-1:0]  maxval_i;
   logic [CH-1:0]    strobe_o;
   logic [CH-1:0]    square_o;
   logic [CH-1:0]    pending_o;

   assign maxval_i = {mv[3], mv[2], mv[1], mv[0]};

   clkgen_multi #(.N(N), .CH(CH)) dut (
      .clk_i     (clk_i),
      .reset     (reset),
      .en_i      (en_i),
      .maxval_i  (maxval_i),
      .load_i    (load_i),
      .sync_i    (sync_i),
      .strobe_o  (strobe_o),
      .square_o  (square_o),
      .pending_o (pending_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int   cyc;
      int   kind;
      int   ch;
      logic exp;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic string kind_name(input int k);
      if (k == 0) return "strobe";
      if (k == 1) return "square";
      return "pending";
   endfunction

   function automatic void push(input int c, input int k, input int ch, input logic e);
      exp_t x;
      x.cyc = c; x.kind = k; x.ch = ch; x.exp = e;
      q.push_back(x);
   endfunction

   function automatic int cnt_le(input int l[$], input int v);
      int n = 0;
      foreach (l[i]) if (l[i] <= v) n++;
      return n;
   endfunction

   function automatic bit in_list(input int l[$], input int v);
      foreach (l[i]) if (l[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   // Per-cycle strobe/square/pending expectations for one channel from its hand-listed strobe cycles.
   function automatic void push_win(input int c0, input int c1, input int ch, input int l[$],
                                    input int p_lo, input int p_hi);
      for (int c = c0; c <= c1; c++) begin
         push(c, 0, ch, in_list(l, c));
`ifdef CLKGEN_MULTI_SQUARE_EN
         push(c, 1, ch, cnt_le(l, c) % 2 == 1);
`else
         push(c, 1, ch, 1'b0);
`endif
         push(c, 2, ch, (c >= p_lo) && (c <= p_hi));
      end
   endfunction

   always @(negedge clk_i) begin
      logic act;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc == cyc) begin
            case (q[i].kind)
               0:       act = strobe_o[q[i].ch];
               1:       act = square_o[q[i].ch];
               default: act = pending_o[q[i].ch];
            endcase
            checks++;
            if (act !== q[i].exp) begin
               errors++;
               $display("FAIL %s[%0d] cycle %0d: got %b expected %b",
                        kind_name(q[i].kind), q[i].ch, cyc, act, q[i].exp);
            end
            q.delete(i);
         end else if (q[i].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale %s[%0d] cycle %0d: never sampled, expected %b",
                     kind_name(q[i].kind), q[i].ch, q[i].cyc, q[i].exp);
            q.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int l[$];
      reset  = 1'b1;
      en_i   = '0;
      load_i = '0;
      sync_i = 1'b0;
      for (int c = 0; c < CH; c++) mv[c] = '0;
      tick();
      tick();

      // cyc 2: outputs after reset are all zero
      for (int c = 0; c < CH; c++) for (int k = 0; k < 3; k++) push(2, k, c, 1'b0);

      reset  = 1'b0;
      sync_i = 1'b1;
      load_i = 4'b1111;
      mv[0] = 16'd3; mv[1] = 16'd9; mv[2] = 16'd4; mv[3] = 16'd5;

      l = '{7, 11, 15, 19, 23, 27, 31};  push_win(3, 32, 0, l, 0, -1);
      l = '{13, 23, 26, 29, 32};         push_win(3, 32, 1, l, 18, 22);
      l = '{8, 13, 19, 25, 31};          push_win(3, 32, 2, l, 10, 12);
      l = '{9, 15, 26, 32};              push_win(3, 32, 3, l, 0, -1);

      tick();
      en_i   = 4'b1111;
      load_i = '0;
      sync_i = 1'b0;

      while (cyc < 48) begin
         tick();
         case (cyc)
            9:  begin load_i = 4'b0100; mv[2] = 16'd7; end
            10: mv[2] = 16'd5;
            11: load_i = '0;
            17: begin load_i = 4'b0010; mv[1] = 16'd2; en_i[3] = 1'b0; end
            18: load_i = '0;
            22: en_i[3] = 1'b1;
            33: begin
               load_i = 4'b0001; mv[0] = 16'd1;
               push(34, 2, 0, 1'b1);
            end
            34: begin
               load_i = 4'b1000; mv[3] = 16'd0; sync_i = 1'b1;
               l = '{37, 39, 41, 43};  push_win(35, 44, 0, l, 0, -1);
               l = '{38, 41, 44};      push_win(35, 44, 1, l, 0, -1);
               l = '{41};              push_win(35, 44, 2, l, 0, -1);
               l = '{};
               for (int c = 36; c <= 44; c++) l.push_back(c);
               push_win(35, 44, 3, l, 0, -1);
            end
            35: begin load_i = '0; sync_i = 1'b0; end
            44: begin
               load_i = 4'b0100; mv[2] = 16'd3;
               push(45, 2, 2, 1'b1);
            end
            45: begin
               load_i = '0; reset = 1'b1;
               for (int c = 0; c < CH; c++) for (int k = 0; k < 3; k++) push(46, k, c, 1'b0);
            end
            46: begin
               reset = 1'b0;
               for (int c = 0; c < CH; c++) begin
                  push(47, 0, c, 1'b1); push(48, 0, c, 1'b1);
                  push(47, 2, c, 1'b0); push(48, 2, c, 1'b0);
               end
            end
            default: ;
         endcase
      end

      repeat (3) tick();
      if (q.size() != 0) begin
         $display("FAIL scoreboard: %0d expectations left unchecked, expected 0", q.size());
         errors += q.size();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
